// File: rtl/cla_mul_seq.sv
// +-----------------------------------------------------------------------------+
// | Module   : cla_mul_seq (with helper cla_16bit)                              |
// | Brief    : 16x16->32 unsigned shift-and-add multiplier over one shared CLA. |
// |            Optional MUL_ZERO_SKIP_EN: zero operands finish on accept edge.  |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] s,
  output logic        g16g,
  output logic        g16p
);
  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [3:0]  w_gc;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Two-level lookahead: 4-bit groups, then a lookahead across the groups.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      localparam int B = 4 * gi;
      assign w_gp[gi] = &w_p[B+3:B];
      assign w_gg[gi] = w_g[B+3]
                      | (w_p[B+3] & w_g[B+2])
                      | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                      | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
      assign w_c[B]   = w_gc[gi];
      assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[gi]);
      assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_gc[gi]);
      assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                      | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[gi]);
    end
  endgenerate

  assign w_gc[0] = c_in;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & c_in);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & c_in);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & c_in);

  assign g16g = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
              | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
  assign g16p = &w_gp;
  assign s    = w_p ^ w_c;
endmodule

module cla_mul_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_mc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_product;

  logic               w_accept;
  logic               w_last;
  logic               w_zero;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_s;
  logic               w_g16g;
  logic               w_g16p;
  logic               w_cin;
  logic               w_co;

`ifdef MUL_ZERO_SKIP_EN
  assign w_zero = (a == '0) || (b == '0);
`else
  assign w_zero = 1'b0;
`endif

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_state == ST_RUN) && (r_cnt == c_LAST_CNT);

  assign w_cin = 1'b0;
  cla_16bit u_cla (
    .a    (r_hi),
    .b    (r_mc),
    .c_in (w_cin),
    .s    (w_sum),
    .g16g (w_g16g),
    .g16p (w_g16p)
  );

  // Only an actual add may produce a carry into the top of hi.
  assign w_s  = r_lo[0] ? w_sum : r_hi;
  assign w_co = r_lo[0] & (w_g16g | (w_g16p & w_cin));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_zero ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_last)   w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (w_accept) w_state_nxt = w_zero ? ST_DONE : ST_RUN;
        else          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_mc      <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_hi  <= '0;
        r_lo  <= b;
        r_mc  <= a;
        r_cnt <= '0;
        if (w_zero) begin
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_product <= '0;
        end else begin
          r_busy <= 1'b1;
        end
      end else if (r_state == ST_RUN) begin
        r_hi  <= {w_co, w_s[WIDTH-1:1]};
        r_lo  <= {w_s[0], r_lo[WIDTH-1:1]};
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_product <= {w_co, w_s, r_lo[WIDTH-1:1]};
        end
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;
endmodule

`default_nettype wire
